dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU data port and one DMA requester.
- The CPU has priority by default. A starvation counter forces a DMA slot and stalls the CPU for that one cycle.
- Sits between the CPU top (mem_addr/mem_wd/mem_rd/mem_ctrl) and the data RAM.
- The RAM has a combinational read path; writes commit on the rising clk edge when ram_we=1.

Parameters:
- CPU_WIDTH, 16, data and address width of all memory paths.
- STARVE_LIMIT, 8, number of consecutive denied DMA cycles that forces a DMA grant (1..2^CNT_W-1).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU performs a data access this cycle (load or store).
- cpu_we  in  1  CPU write enable (the CPU's mem_ctrl).
- cpu_addr  in  CPU_WIDTH  CPU access address.
- cpu_wd  in  CPU_WIDTH  CPU write data.
- cpu_rd  out  CPU_WIDTH  CPU read data.
- cpu_stall  out  1  CPU must hold PC, request and register writeback this cycle.
- dma_req  in  1  DMA access pending; request fields held stable until dma_gnt.
- dma_we  in  1  DMA write enable.
- dma_addr  in  CPU_WIDTH  DMA address.
- dma_wd  in  CPU_WIDTH  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  registered DMA read data valid.
- dma_rd  out  CPU_WIDTH  registered DMA read data.
- owner  out  2  registered owner of the previous cycle: 0 idle, 1 cpu, 2 dma, 3 forced-dma.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  CPU_WIDTH  RAM address.
- ram_wd  out  CPU_WIDTH  RAM write data.
- ram_rd  in  CPU_WIDTH  RAM read data (combinational).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge.
- Reset values: wait_cnt=0, owner=0, dma_rvalid=0, dma_rd=0.
- Reset mid-operation: any pending dma_rvalid is dropped. Combinational outputs follow the inputs even while in reset, but ram_en, ram_we, dma_gnt and cpu_stall are forced to 0 while rst_n=0.
- Grant decision is combinational each cycle:
  - force = dma_req && (wait_cnt == STARVE_LIMIT).
  - dma_gnt = dma_req && (!cpu_req || force).
  - cpu_stall = cpu_req && dma_gnt, so a stall only occurs in a forced cycle.
  - CPU path active = cpu_req && !cpu_stall.
- RAM mux:
  - When dma_gnt: ram_addr=dma_addr, ram_wd=dma_wd, ram_we=dma_we.
  - Otherwise: ram_addr=cpu_addr, ram_wd=cpu_wd, ram_we=cpu_we && cpu_req.
  - ram_en = dma_gnt || cpu_req (CPU path active).
- Read data paths:
  - cpu_rd = ram_rd whenever the CPU path is active. Otherwise cpu_rd = 0 (it is don't-care to the CPU, but drive 0).
  - DMA read: a grant with dma_we=0 gives dma_rvalid=1 and dma_rd=ram_rd on the next cycle (latency 1). In all other cycles dma_rvalid=0 and dma_rd holds its last value.
  - DMA write: no dma_rvalid.
- Starvation counter:
  - If dma_req && !dma_gnt: wait_cnt += 1, saturating at STARVE_LIMIT.
  - Else (grant or no request): wait_cnt = 0.
  - The counter cannot re-reach the limit before STARVE_LIMIT more CPU-won cycles, so at most 1 forced slot per STARVE_LIMIT+1 cycles.
- Owner register updates every cycle: 3 if forced grant, 2 if DMA grant, 1 if CPU path active, else 0.
- Boundary cases:
  - Simultaneous requests below the limit: CPU wins, DMA waits.
  - Requests at the limit: DMA wins, CPU stalls exactly 1 cycle, and the CPU wins the following cycle.
  - dma_req dropped while waiting: the counter clears and no grant is issued.
  - Back-to-back DMA requests with the CPU idle: a grant every cycle, and dma_rvalid is asserted continuously.

Decomposition:
- Shared package (dmem_arb_pkg): owner encodings OWN_IDLE=0, OWN_CPU=1, OWN_DMA=2, OWN_FORCE=3, and the default STARVE_LIMIT.
- One sub-module, arb_starve_cnt: saturating counter with inc/clr inputs and an at_limit output.
- The mux, grant logic and DMA read register stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> owner=0, dma_rvalid=0, ram_en=0, cpu_stall=0.
- CPU only: cpu_req=1, cpu_we=1, addr=0x0010, wd=0xBEEF, then a read of 0x0010 -> ram_we pulses, and cpu_rd=0xBEEF the same cycle as the read.
- DMA only: dma read of 0x0020 (pre-loaded 0x1234) with cpu_req=0 -> dma_gnt=1 in cycle N; dma_rvalid=1 and dma_rd=0x1234 in N+1; owner=2.
- Contention: cpu_req=1 and dma_req=1 held continuously, STARVE_LIMIT=8 ->
  - Cycles 0-7: CPU wins, wait_cnt reaches 8.
  - Cycle 8: dma_gnt=1, cpu_stall=1, owner=3 next cycle.
  - Cycle 9: CPU wins, wait_cnt restarts at 0.
  - Pattern repeats with period 9.
- Withdrawal: dma_req=1 for 5 denied cycles, then 0 -> wait_cnt=0, no dma_gnt, no cpu_stall.
- Reset mid-read: DMA read granted in cycle N, rst_n=0 in N+1 -> dma_rvalid=0 after the edge and wait_cnt=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encodings and default
// starvation parameters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_DMA   = 2'd2,
    OWN_FORCE = 2'd3
  } owner_t;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int CNT_W_DEF        = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles in which a pending DMA request was
// denied; at_limit tells the arbiter to force a DMA slot.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF,
  parameter int W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;

  assign at_limit = (count == LIM);

  // clr wins over inc; the count parks at LIM until cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and one DMA
// requester. CPU has priority; a starved DMA request steals one slot.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int CPU_WIDTH    = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [CPU_WIDTH-1:0] cpu_addr,
  input  logic [CPU_WIDTH-1:0] cpu_wd,
  output logic [CPU_WIDTH-1:0] cpu_rd,
  output logic                 cpu_stall,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [CPU_WIDTH-1:0] dma_addr,
  input  logic [CPU_WIDTH-1:0] dma_wd,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [CPU_WIDTH-1:0] dma_rd,
  output logic [1:0]           owner,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [CPU_WIDTH-1:0] ram_addr,
  output logic [CPU_WIDTH-1:0] ram_wd,
  input  logic [CPU_WIDTH-1:0] ram_rd
);

  // DMA handshake: dma_req with its fields is held stable until a cycle in
  // which dma_gnt=1; that cycle performs the access. Reads return data one
  // cycle later on dma_rvalid/dma_rd; writes produce no response.

  logic   at_limit;
  logic   force_slot;
  logic   cpu_active;
  logic   starve_inc;
  owner_t owner_q;
  owner_t owner_next;

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clr      (!starve_inc),
    .at_limit (at_limit)
  );

  assign force_slot = dma_req && at_limit;
  assign dma_gnt    = rst_n && dma_req && (!cpu_req || force_slot);
  assign cpu_stall  = cpu_req && dma_gnt;
  assign cpu_active = cpu_req && !cpu_stall;
  assign starve_inc = dma_req && !dma_gnt;

  assign ram_addr = dma_gnt ? dma_addr : cpu_addr;
  assign ram_wd   = dma_gnt ? dma_wd   : cpu_wd;
  assign ram_we   = rst_n && (dma_gnt ? dma_we : (cpu_we && cpu_req));
  assign ram_en   = rst_n && (dma_gnt || cpu_active);
  assign cpu_rd   = cpu_active ? ram_rd : '0;

  always_comb begin
    owner_next = OWN_IDLE;
    if (dma_gnt && force_slot) begin
      owner_next = OWN_FORCE;
    end else if (dma_gnt) begin
      owner_next = OWN_DMA;
    end else if (cpu_active) begin
      owner_next = OWN_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= OWN_IDLE;
      dma_rvalid <= 1'b0;
      dma_rd     <= '0;
    end else begin
      owner_q    <= owner_next;
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we) begin
        dma_rd <= ram_rd;
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural RAM and a queue of
// expected DMA read data.
module tb_dmem_arbiter;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [W-1:0] cpu_addr, cpu_wd, cpu_rd;
  logic         cpu_stall;
  logic         dma_req, dma_we;
  logic [W-1:0] dma_addr, dma_wd;
  logic         dma_gnt, dma_rvalid;
  logic [W-1:0] dma_rd;
  logic [1:0]   owner;
  logic         ram_en, ram_we;
  logic [W-1:0] ram_addr, ram_wd, ram_rd;

  logic         bd_we;
  logic [7:0]   bd_addr;
  logic [W-1:0] bd_wd;
  logic [W-1:0] mem [0:255];
  logic [W-1:0] ref_mem [0:255];

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  dmem_arbiter #(.CPU_WIDTH(W), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rd(dma_rd),
    .owner(owner),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_rd(ram_rd)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: combinational read, write on rising edge
  assign ram_rd = mem[ram_addr[7:0]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wd;
    else if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wd;
  end

  // Scoreboard: DMA read data is compared in the cycle dma_rvalid is seen
  always @(negedge clk) begin
    if (dma_rvalid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_rvalid: got dma_rd=%h, required no rvalid", dma_rd);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dma_rd !== e) begin
          n_fail++;
          $display("FAIL sb_dma_rd: got %h required %h", dma_rd, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wd = d;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wd = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, '0, '0);
    bd_we = 1'b1; bd_addr = 8'h20; bd_wd = 16'h1234;
    step();
    bd_we = 1'b0;
    ref_mem[8'h20] = 16'h1234;
    drive_cpu(1, 1, 16'h0040, 16'h5555);
    drive_dma(1, 1, 16'h0044, 16'h6666);
    #2;
    n_checks++;
    if ({ram_en, ram_we, dma_gnt, cpu_stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_gating: got en/we/gnt/stall=%b required 0000", {ram_en, ram_we, dma_gnt, cpu_stall});
    end
    step();
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, '0, '0);
    rst_n = 1'b1;
    n_checks++;
    if (owner !== 2'd0 || dma_rvalid !== 1'b0 || dma_rd !== '0) begin
      n_fail++;
      $display("FAIL rst_values: got owner=%0d rvalid=%b rd=%h required 0 0 0000", owner, dma_rvalid, dma_rd);
    end
    #2;
    n_checks++;
    if (ram_en !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_comb: got ram_en=%b stall=%b required 0 0", ram_en, cpu_stall);
    end
    step();
    n_checks++;
    if (owner !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_owner: got %0d required 0", owner);
    end
  endtask

  task automatic test_cpu_only();
    drive_cpu(1, 1, 16'h0010, 16'hBEEF);
    ref_mem[8'h10] = 16'hBEEF;
    #2;
    n_checks++;
    if ({ram_en, ram_we, dma_gnt} !== 3'b110 || ram_addr !== 16'h0010 || ram_wd !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL cpu_write: got en/we/gnt=%b addr=%h wd=%h required 110 0010 beef", {ram_en, ram_we, dma_gnt}, ram_addr, ram_wd);
    end
    step();
    n_checks++;
    if (owner !== 2'd1) begin
      n_fail++;
      $display("FAIL cpu_write_owner: got %0d required 1", owner);
    end
    drive_cpu(1, 0, 16'h0010, 16'h0000);
    #2;
    n_checks++;
    if (cpu_rd !== ref_mem[8'h10] || ram_we !== 1'b0 || ram_en !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_read: got rd=%h we=%b en=%b required %h 0 1", cpu_rd, ram_we, ram_en, ref_mem[8'h10]);
    end
    step();
    drive_cpu(0, 0, '0, '0);
  endtask

  task automatic test_dma_only();
    drive_dma(1, 0, 16'h0020, 16'h0000);
    exp_q.push_back(ref_mem[8'h20]);
    #2;
    n_checks++;
    if (dma_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_addr !== 16'h0020 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL dma_grant: got gnt=%b stall=%b addr=%h we=%b required 1 0 0020 0", dma_gnt, cpu_stall, ram_addr, ram_we);
    end
    step();
    drive_dma(0, 0, '0, '0);
    n_checks++;
    if (dma_rvalid !== 1'b1 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL dma_resp: got rvalid=%b owner=%0d required 1 2", dma_rvalid, owner);
    end
    step();
    n_checks++;
    if (dma_rvalid !== 1'b0 || dma_rd !== 16'h1234) begin
      n_fail++;
      $display("FAIL dma_hold: got rvalid=%b rd=%h required 0 1234", dma_rvalid, dma_rd);
    end
  endtask

  // Both sides requesting; a forced slot is expected every 9th cycle
  task automatic run_contention(input int cycles, input int first_force, input string tag);
    drive_cpu(1, 0, 16'h0010, 16'h0000);
    drive_dma(1, 1, 16'h0030, 16'hCAFE);
    for (int i = 0; i < cycles; i++) begin
      logic f;
      f = (i >= first_force) && ((i - first_force) % 9 == 0);
      if (f) ref_mem[8'h30] = 16'hCAFE;
      #2;
      n_checks++;
      if (dma_gnt !== f || cpu_stall !== f || ram_we !== f ||
          ram_addr !== (f ? 16'h0030 : 16'h0010) || cpu_rd !== (f ? 16'h0000 : ref_mem[8'h10])) begin
        n_fail++;
        $display("FAIL %s_c%0d: got gnt=%b stall=%b we=%b addr=%h cpu_rd=%h required forced=%b", tag, i, dma_gnt, cpu_stall, ram_we, ram_addr, cpu_rd, f);
      end
      step();
      n_checks++;
      if (owner !== (f ? 2'd3 : 2'd1)) begin
        n_fail++;
        $display("FAIL %s_owner%0d: got %0d required %0d", tag, i, owner, f ? 3 : 1);
      end
    end
  endtask

  task automatic test_contention();
    run_contention(18, 8, "contend");
    drive_dma(0, 0, '0, '0);
    step();
  endtask

  task automatic test_withdrawal();
    run_contention(5, 99, "wd_pre");
    drive_dma(0, 0, '0, '0);
    #2;
    n_checks++;
    if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw: got gnt=%b stall=%b required 0 0", dma_gnt, cpu_stall);
    end
    step();
    run_contention(9, 8, "wd_post");
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, '0, '0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [4];
    addrs[0] = 8'h20; addrs[1] = 8'h10; addrs[2] = 8'h30; addrs[3] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      drive_dma(1, 0, {8'h00, addrs[k]}, 16'h0000);
      exp_q.push_back(ref_mem[addrs[k]]);
      #2;
      n_checks++;
      if (dma_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gnt%0d: got %b required 1", k, dma_gnt);
      end
      step();
      n_checks++;
      if (dma_rvalid !== 1'b1 || owner !== 2'd2) begin
        n_fail++;
        $display("FAIL b2b_rvalid%0d: got rvalid=%b owner=%0d required 1 2", k, dma_rvalid, owner);
      end
    end
    drive_dma(0, 0, '0, '0);
    step();
    n_checks++;
    if (dma_rvalid !== 1'b0 || dma_rd !== ref_mem[8'h20]) begin
      n_fail++;
      $display("FAIL b2b_end: got rvalid=%b rd=%h required 0 %h", dma_rvalid, dma_rd, ref_mem[8'h20]);
    end
  endtask

  task automatic test_reset_mid_read();
    drive_dma(1, 0, 16'h0010, 16'h0000);
    exp_q.push_back(ref_mem[8'h10]);
    step();
    rst_n = 1'b0;
    drive_dma(0, 0, '0, '0);
    step();
    rst_n = 1'b1;
    n_checks++;
    if (dma_rvalid !== 1'b0 || owner !== 2'd0 || dma_rd !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got rvalid=%b owner=%0d rd=%h required 0 0 0000", dma_rvalid, owner, dma_rd);
    end
    // Partially fill the starvation counter, then reset with requests held
    run_contention(4, 99, "pre_rst");
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({ram_en, dma_gnt, cpu_stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_held_req: got en/gnt/stall=%b required 000", {ram_en, dma_gnt, cpu_stall});
    end
    step();
    rst_n = 1'b1;
    run_contention(9, 8, "post_rst");
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, '0, '0);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bd_we = 1'b0; bd_addr = '0; bd_wd = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_contention();
    test_withdrawal();
    test_back_to_back();
    test_reset_mid_read();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending reads required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
